alu_sequencer: RTL and testbench

Initiator side of the ALU operand/select interface: accepts one 16-bit instruction at a time through a valid/ready handshake. Holds a small register file, drives ALU operands and select, captures the ALU result, writes back, and signals completion. Sits between the instruction source (fetch/testbench) and the combinational ALU in the 8-bit CPU datapath.

---
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction sequencer in front of a combinational ALU.
// Takes one instruction per handshake, reads a small register file, drives
// registered ALU operands/select, captures the result and writes it back.
// Optional build macro: ALU_SEQ_FLAGS_EN (registered zero/negative flags).
module alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [REG_AW-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              halted,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              zero_flag,
    output logic              neg_flag
);

    localparam int NREGS = 1 << REG_AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t state, state_nx;

    // Latched instruction fields (bit 8 of instr carries nothing)
    logic [2:0]        op;
    logic [REG_AW-1:0] rd, rs;
    logic [DATA_W-1:0] imm;

    logic [NREGS-1:0][DATA_W-1:0] rf;
    logic [DATA_W-1:0] result;
    logic [2:0]        sel_nx;
    logic              accept;
    logic              unused_bits;

    assign unused_bits = instr[8];
    assign accept      = instr_valid && instr_ready;
    assign instr_ready = (state == S_IDLE);
    assign halted      = (state == S_HALTED);
    assign dbg_data    = rf[dbg_addr];

    // Next-state logic and ALU select mapping (LDI reuses MOV, NOP reuses ADD)
    always_comb begin
        state_nx = state;
        sel_nx   = OP_ADD;
        if (op <= OP_MOV) sel_nx = op;
        else if (op == OP_LDI) sel_nx = OP_MOV;
        case (state)
            S_IDLE:   if (accept) state_nx = S_DECODE;
            S_DECODE: state_nx = (op == OP_HLT) ? S_HALTED : S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB:     state_nx = S_IDLE;
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Instruction latch at handshake; source may change instr afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op  <= '0;
            rd  <= '0;
            rs  <= '0;
            imm <= '0;
        end else if (accept) begin
            op  <= instr[15:13];
            rd  <= REG_AW'(instr[12:11]);
            rs  <= REG_AW'(instr[10:9]);
            imm <= DATA_W'(instr[7:0]);
        end
    end

    // Operand/select registers loaded in DECODE, before any write-back of rd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else if (state == S_DECODE) begin
            alu_a   <= rf[rd];
            alu_b   <= (op == OP_LDI) ? imm : rf[rs];
            alu_sel <= sel_nx;
        end
    end

    // Capture the ALU output one cycle after operands settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 result <= '0;
        else if (state == S_EXEC) result <= alu_result;
    end

    // Write-back and completion pulse; NOP reports but does not write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf        <= '0;
            done      <= 1'b0;
            done_rd   <= '0;
            done_data <= '0;
        end else begin
            done <= (state == S_WB);
            if (state == S_WB) begin
                done_rd   <= rd;
                done_data <= result;
                if (op != OP_NOP) rf[rd] <= result;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Status flags follow every written result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (state == S_WB && op != OP_NOP) begin
            zero_flag <= (result == '0);
            neg_flag  <= result[DATA_W-1];
        end
    end
`else
    assign zero_flag = 1'b0;
    assign neg_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [15:0] instr = '0;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       done;
    logic [1:0] done_rd;
    logic [7:0] done_data;
    logic       halted;
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;
    logic       zero_flag, neg_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(8), .REG_AW(2)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .done(done), .done_rd(done_rd), .done_data(done_data), .halted(halted),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .zero_flag(zero_flag), .neg_flag(neg_flag)
    );

    // Combinational ALU the sequencer drives
    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 1'b0, imm};
    endfunction

    // Issue one instruction and follow it to its done pulse
    task automatic run(input logic [15:0] ins, input logic [2:0] esel,
                       input logic [1:0] erd, input logic [7:0] edata, input string nm);
        int w = 0;
        logic exp;
        while (instr_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            $display("FAIL %s: ready_timeout actual=%b required=1", nm, instr_ready);
            errors++;
            return;
        end
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'hE000;  // HALT pattern on the bus; must be ignored while busy
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            exp = (k == 3);
            checks++;
            if (done !== exp) begin
                $display("FAIL %s: done@%0d actual=%b required=%b", nm, k, done, exp);
                errors++;
            end
            checks++;
            if (instr_ready !== exp) begin
                $display("FAIL %s: ready@%0d actual=%b required=%b", nm, k, instr_ready, exp);
                errors++;
            end
            if (k == 1) begin
                checks++;
                if (alu_sel !== esel) begin
                    $display("FAIL %s: alu_sel actual=%h required=%h", nm, alu_sel, esel);
                    errors++;
                end
            end
        end
        checks++;
        if (done_rd !== erd || done_data !== edata) begin
            $display("FAIL %s: done_rd/data actual=%0d/%h required=%0d/%h",
                     nm, done_rd, done_data, erd, edata);
            errors++;
        end
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [7:0] v, input string nm);
        dbg_addr = a;
        #1;
        checks++;
        if (dbg_data !== v) begin
            $display("FAIL %s: R%0d actual=%h required=%h", nm, a, dbg_data, v);
            errors++;
        end
    endtask

    task automatic chk_flags(input logic ez, input logic en, input string nm);
`ifndef ALU_SEQ_FLAGS_EN
        ez = 1'b0;
        en = 1'b0;
`endif
        checks++;
        if (zero_flag !== ez || neg_flag !== en) begin
            $display("FAIL %s: z/n actual=%b/%b required=%b/%b", nm, zero_flag, neg_flag, ez, en);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL reset_ctrl: rdy/done/halt actual=%b%b%b required=100",
                     instr_ready, done, halted);
            errors++;
        end
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 3'b000 ||
            done_rd !== 2'd0 || done_data !== 8'h00) begin
            $display("FAIL reset_regs: a/b/sel/rd/data actual=%h/%h/%h/%0d/%h required=0",
                     alu_a, alu_b, alu_sel, done_rd, done_data);
            errors++;
        end
        chk_flags(1'b0, 1'b0, "reset_flags");
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00, "reset_rf");
    endtask

    task automatic test_add();
        run(enc(3'b101, 2'd1, 2'd0, 8'h05), 3'b100, 2'd1, 8'h05, "ldi_r1");
        run(enc(3'b101, 2'd2, 2'd0, 8'h03), 3'b100, 2'd2, 8'h03, "ldi_r2");
        run(enc(3'b000, 2'd1, 2'd2, 8'h00), 3'b000, 2'd1, 8'h08, "add");
        chk_reg(2'd1, 8'h08, "add_r1");
        chk_reg(2'd2, 8'h03, "add_r2");
    endtask

    task automatic test_sub_wrap();
        run(enc(3'b101, 2'd0, 2'd0, 8'h00), 3'b100, 2'd0, 8'h00, "ldi_r0");
        run(enc(3'b101, 2'd3, 2'd0, 8'h01), 3'b100, 2'd3, 8'h01, "ldi_r3");
        run(enc(3'b001, 2'd0, 2'd3, 8'h00), 3'b001, 2'd0, 8'hFF, "sub_wrap");
        chk_reg(2'd0, 8'hFF, "sub_r0");
        chk_flags(1'b0, 1'b1, "sub_flags");
        run(enc(3'b000, 2'd0, 2'd3, 8'h00), 3'b000, 2'd0, 8'h00, "add_wrap");
        chk_flags(1'b1, 1'b0, "add_wrap_flags");
    endtask

    task automatic test_logic();
        run(enc(3'b101, 2'd1, 2'd0, 8'hF0), 3'b100, 2'd1, 8'hF0, "ldi_f0");
        run(enc(3'b101, 2'd2, 2'd0, 8'h3C), 3'b100, 2'd2, 8'h3C, "ldi_3c");
        run(enc(3'b010, 2'd1, 2'd2, 8'h00), 3'b010, 2'd1, 8'h30, "and");
        run(enc(3'b011, 2'd1, 2'd2, 8'h00), 3'b011, 2'd1, 8'h3C, "or");
        run(enc(3'b100, 2'd3, 2'd1, 8'h00), 3'b100, 2'd3, 8'h3C, "mov");
        chk_reg(2'd3, 8'h3C, "mov_r3");
        chk_reg(2'd1, 8'h3C, "mov_r1");
    endtask

    // valid held high across LDI R0,80 / NOP R0,R0 / ADD R2,R0
    task automatic test_back_to_back();
        logic [15:0] prog [3];
        logic [7:0]  edat [3];
        logic [1:0]  erd  [3];
        int acc_cyc [3];
        int idx = 0, nd = 0;
        logic rdy;
        prog[0] = enc(3'b101, 2'd0, 2'd0, 8'h80); edat[0] = 8'h80; erd[0] = 2'd0;
        prog[1] = enc(3'b110, 2'd0, 2'd0, 8'h00); edat[1] = 8'h00; erd[1] = 2'd0;
        prog[2] = enc(3'b000, 2'd2, 2'd0, 8'h00); edat[2] = 8'hBC; erd[2] = 2'd2;
        instr_valid = 1'b1;
        instr = prog[0];
        for (int c = 0; c < 20; c++) begin
            rdy = instr_ready;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                checks++;
                if (nd >= idx || nd > 2 || c != acc_cyc[nd] + 3) begin
                    $display("FAIL b2b_done_timing: cycle actual=%0d pulse=%0d", c, nd);
                    errors++;
                end else if (done_rd !== erd[nd] || done_data !== edat[nd]) begin
                    $display("FAIL b2b_done_val: rd/data actual=%0d/%h required=%0d/%h",
                             done_rd, done_data, erd[nd], edat[nd]);
                    errors++;
                end
                if (nd == 1) chk_flags(1'b0, 1'b1, "nop_keeps_flags");
                nd++;
            end
            if (rdy && idx < 3) begin
                acc_cyc[idx] = c;
                if (idx > 0) begin
                    checks++;
                    if (c - acc_cyc[idx-1] != 4) begin
                        $display("FAIL b2b_spacing: actual=%0d required=4", c - acc_cyc[idx-1]);
                        errors++;
                    end
                end
                idx++;
                if (idx < 3) instr = prog[idx];
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (idx != 3 || nd != 3) begin
            $display("FAIL b2b_count: accepts/dones actual=%0d/%0d required=3/3", idx, nd);
            errors++;
        end
        chk_reg(2'd0, 8'h80, "nop_no_write");
        chk_reg(2'd2, 8'hBC, "b2b_r2");
    endtask

    task automatic test_halt();
        int w = 0;
        while (instr_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        instr_valid = 1'b1;
        instr = enc(3'b111, 2'd0, 2'd0, 8'h00);
        @(posedge clk); #1;
        instr = enc(3'b101, 2'd0, 2'd0, 8'h55);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || instr_ready !== 1'b0 || halted !== 1'b1) begin
                $display("FAIL halt@%0d: done/rdy/halt actual=%b%b%b required=001",
                         k, done, instr_ready, halted);
                errors++;
            end
        end
        instr_valid = 1'b0;
        chk_reg(2'd0, 8'h80, "halt_r0");
        chk_reg(2'd1, 8'h3C, "halt_r1");
        chk_reg(2'd2, 8'hBC, "halt_r2");
        chk_reg(2'd3, 8'h3C, "halt_r3");
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++;
        if (halted !== 1'b0 || instr_ready !== 1'b1) begin
            $display("FAIL unhalt: halt/rdy actual=%b%b required=01", halted, instr_ready);
            errors++;
        end
        instr_valid = 1'b1;
        instr = enc(3'b101, 2'd2, 2'd0, 8'hAA);
        @(posedge clk); #1;       // accepted, now DECODE
        instr_valid = 1'b0;
        @(posedge clk); #1;       // EXEC
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            $display("FAIL rst_mid: rdy/done actual=%b%b required=10", instr_ready, done);
            errors++;
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                $display("FAIL rst_mid_done@%0d: actual=%b required=0", k, done);
                errors++;
            end
        end
        chk_reg(2'd2, 8'h00, "rst_mid_r2");
        chk_reg(2'd0, 8'h00, "rst_mid_r0");
        run(enc(3'b101, 2'd2, 2'd0, 8'h5A), 3'b100, 2'd2, 8'h5A, "post_rst");
        chk_reg(2'd2, 8'h5A, "post_rst_r2");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_logic();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
